// File: rtl/seg7_pkg.sv
// Shared 7-segment constants (active-low, bit0=a .. bit6=g).
// Used by the hex encoder and by the decode monitor.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h18;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational inverse of the hex-to-7-segment encoder.
// valid is low for any pattern outside the 16-entry table.
module seg7_to_hex
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic       valid,
    output logic [3:0] hex
);

    always_comb begin
        valid = 1'b1;
        hex   = 4'h0;
        case (seg)
            SEG_0:   hex = 4'h0;
            SEG_1:   hex = 4'h1;
            SEG_2:   hex = 4'h2;
            SEG_3:   hex = 4'h3;
            SEG_4:   hex = 4'h4;
            SEG_5:   hex = 4'h5;
            SEG_6:   hex = 4'h6;
            SEG_7:   hex = 4'h7;
            SEG_8:   hex = 4'h8;
            SEG_9:   hex = 4'h9;
            SEG_A:   hex = 4'hA;
            SEG_B:   hex = 4'hB;
            SEG_C:   hex = 4'hC;
            SEG_D:   hex = 4'hD;
            SEG_E:   hex = 4'hE;
            SEG_F:   hex = 4'hF;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_decode_monitor.sv
// Debounces a scanned active-low segment bus and rebuilds the display digits.
// Option: define SEG7_BLANK_DETECT_EN to treat a stable all-off pattern as a blank digit.
module seg7_decode_monitor
    import seg7_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int IDX_W         = 2,
    parameter int STABLE_CYCLES = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  sample_en,
    input  logic [6:0]            seg_in,
    input  logic [IDX_W-1:0]      digit_idx,
    output logic [4*DIGITS-1:0]   hex_out,
    output logic [DIGITS-1:0]     digit_valid,
    output logic                  commit,
    output logic [IDX_W-1:0]      commit_idx,
    output logic                  err,
    output logic [7:0]            err_cnt,
    output logic                  frame_done
);

    localparam logic [3:0]     STABLE  = 4'(STABLE_CYCLES);
    localparam logic [IDX_W:0] DIG_LIM = (IDX_W+1)'(DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    logic [6:0]          last_pat_q, last_pat_d;
    logic [IDX_W-1:0]    last_idx_q, last_idx_d;
    logic [3:0]          run_q, run_d;
    logic [4*DIGITS-1:0] hex_q, hex_d;
    logic [DIGITS-1:0]   valid_q, valid_d;
    logic                commit_q, commit_d;
    logic [IDX_W-1:0]    commit_idx_q, commit_idx_d;
    logic                err_q, err_d;
    logic [7:0]          err_cnt_q, err_cnt_d;
    logic                frame_q, frame_d;

    logic                dec_valid;
    logic [3:0]          dec_hex;
    logic                idx_ok;
    logic                same;
    logic                fire;

    seg7_to_hex u_dec (
        .seg   (seg_in),
        .valid (dec_valid),
        .hex   (dec_hex)
    );

    always_comb begin
        last_pat_d   = last_pat_q;
        last_idx_d   = last_idx_q;
        run_d        = run_q;
        hex_d        = hex_q;
        valid_d      = valid_q;
        commit_d     = 1'b0;
        commit_idx_d = commit_idx_q;
        err_d        = 1'b0;
        err_cnt_d    = err_cnt_q;
        frame_d      = 1'b0;
        same         = 1'b0;
        fire         = 1'b0;
        idx_ok       = {1'b0, digit_idx} < DIG_LIM;

        if (sample_en) begin
            if (!idx_ok) begin
                run_d = 4'd0;
            end else begin
                same = (seg_in == last_pat_q) &&
                       (digit_idx == last_idx_q) &&
                       (run_q != 4'd0);
                if (same) begin
                    // Saturated runs stay put so a held digit commits once.
                    if (run_q < STABLE) begin
                        run_d = run_q + 4'd1;
                        fire  = (run_q + 4'd1) == STABLE;
                    end
                end else begin
                    last_pat_d = seg_in;
                    last_idx_d = digit_idx;
                    run_d      = 4'd1;
                    fire       = (STABLE == 4'd1);
                end
            end
        end

        if (fire) begin
            if (dec_valid) begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (digit_idx == IDX_W'(i)) begin
                        hex_d[4*i +: 4] = dec_hex;
                        valid_d[i]      = 1'b1;
                    end
                end
                commit_d     = 1'b1;
                commit_idx_d = digit_idx;
            end
`ifdef SEG7_BLANK_DETECT_EN
            else if (seg_in == SEG_BLANK) begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (digit_idx == IDX_W'(i)) begin
                        valid_d[i] = 1'b0;
                    end
                end
            end
`endif
            else begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (digit_idx == IDX_W'(i)) begin
                        valid_d[i] = 1'b0;
                    end
                end
                err_d = 1'b1;
                if (err_cnt_q != 8'hFF) begin
                    err_cnt_d = err_cnt_q + 8'd1;
                end
            end
        end

        frame_d = commit_d && (digit_idx == LAST_IDX) && (&valid_d);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            last_pat_q   <= SEG_BLANK;
            last_idx_q   <= '0;
            run_q        <= 4'd0;
            hex_q        <= '0;
            valid_q      <= '0;
            commit_q     <= 1'b0;
            commit_idx_q <= '0;
            err_q        <= 1'b0;
            err_cnt_q    <= 8'd0;
            frame_q      <= 1'b0;
        end else begin
            last_pat_q   <= last_pat_d;
            last_idx_q   <= last_idx_d;
            run_q        <= run_d;
            hex_q        <= hex_d;
            valid_q      <= valid_d;
            commit_q     <= commit_d;
            commit_idx_q <= commit_idx_d;
            err_q        <= err_d;
            err_cnt_q    <= err_cnt_d;
            frame_q      <= frame_d;
        end
    end

    assign hex_out     = hex_q;
    assign digit_valid = valid_q;
    assign commit      = commit_q;
    assign commit_idx  = commit_idx_q;
    assign err         = err_q;
    assign err_cnt     = err_cnt_q;
    assign frame_done  = frame_q;

endmodule

// File: tb/tb_seg7_decode_monitor.sv
// Randomized + directed bench for seg7_decode_monitor with a run-length model.
// Build with SEG7_BLANK_DETECT_EN to check the blank-digit option.
module tb_seg7_decode_monitor;

    localparam int DIGITS = 4;
    localparam int IDX_W  = 2;
    localparam int STABLE = 3;

    logic                clock = 1'b0;
    logic                reset = 1'b0;
    logic                sample_en = 1'b0;
    logic [6:0]          seg_in = 7'h7F;
    logic [IDX_W-1:0]    digit_idx = '0;
    logic [4*DIGITS-1:0] hex_out;
    logic [DIGITS-1:0]   digit_valid;
    logic                commit;
    logic [IDX_W-1:0]    commit_idx;
    logic                err;
    logic [7:0]          err_cnt;
    logic                frame_done;

    int checks = 0;
    int errors = 0;

    logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30,
                             7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h18, 7'h08, 7'h03,
                             7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model state
    logic [3:0]        m_hex [DIGITS];
    logic [DIGITS-1:0] m_valid;
    int                m_err_cnt;
    logic [6:0]        m_last_pat;
    int                m_last_idx;
    int                m_run;
    logic              e_commit, e_err, e_frame;
    logic [IDX_W-1:0]  e_idx;

    seg7_decode_monitor #(
        .DIGITS        (DIGITS),
        .IDX_W         (IDX_W),
        .STABLE_CYCLES (STABLE)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .sample_en   (sample_en),
        .seg_in      (seg_in),
        .digit_idx   (digit_idx),
        .hex_out     (hex_out),
        .digit_valid (digit_valid),
        .commit      (commit),
        .commit_idx  (commit_idx),
        .err         (err),
        .err_cnt     (err_cnt),
        .frame_done  (frame_done)
    );

    always #5 clock = ~clock;

    function automatic logic [4*DIGITS-1:0] m_hex_vec();
        logic [4*DIGITS-1:0] v;
        for (int i = 0; i < DIGITS; i++) v[4*i +: 4] = m_hex[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DIGITS; i++) m_hex[i] = 4'h0;
        m_valid    = '0;
        m_err_cnt  = 0;
        m_last_pat = 7'h7F;
        m_last_idx = 0;
        m_run      = 0;
        e_commit   = 0;
        e_err      = 0;
        e_frame    = 0;
        e_idx      = '0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset     = 1'b0;
        sample_en = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        model_reset();
    endtask

    // One clock with the given strobe; model predicts post-edge outputs.
    task automatic drive(input logic en, input logic [6:0] seg,
                         input logic [IDX_W-1:0] idx);
        bit fire;
        bit found;
        logic [3:0] d;
        @(negedge clock);
        sample_en = en;
        seg_in    = seg;
        digit_idx = idx;
        @(posedge clock);
        #1;
        sample_en = 1'b0;
        e_commit = 0;
        e_err    = 0;
        e_frame  = 0;
        fire     = 0;
        if (en) begin
            if (int'(idx) >= DIGITS) begin
                m_run = 0;
            end else if (seg == m_last_pat && int'(idx) == m_last_idx
                         && m_run != 0) begin
                if (m_run < STABLE) begin
                    m_run++;
                    fire = (m_run == STABLE);
                end
            end else begin
                m_last_pat = seg;
                m_last_idx = int'(idx);
                m_run      = 1;
                fire       = (STABLE == 1);
            end
        end
        if (fire) begin
            found = 0;
            d     = 4'h0;
            for (int k = 0; k < 16; k++) begin
                if (tbl[k] == seg) begin
                    found = 1;
                    d     = k[3:0];
                end
            end
            if (found) begin
                m_hex[idx]   = d;
                m_valid[idx] = 1'b1;
                e_commit     = 1;
                e_idx        = idx;
                e_frame      = (int'(idx) == DIGITS-1) && (&m_valid);
            end else begin
                m_valid[idx] = 1'b0;
`ifdef SEG7_BLANK_DETECT_EN
                if (seg != 7'h7F) begin
                    e_err = 1;
                    if (m_err_cnt < 255) m_err_cnt++;
                end
`else
                e_err = 1;
                if (m_err_cnt < 255) m_err_cnt++;
`endif
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (hex_out !== '0) begin
            errors++;
            $display("FAIL rst_hex got %h exp 0", hex_out);
        end
        checks++;
        if (digit_valid !== '0 || commit !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL rst_flags got v=%b c=%b e=%b exp 0",
                     digit_valid, commit, err);
        end
        checks++;
        if (err_cnt !== 8'd0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL rst_cnt got %0d f=%b exp 0", err_cnt, frame_done);
        end
    endtask

    task automatic test_table();
        int ncommit = 0;
        for (int k = 0; k < 16; k++) begin
            for (int s = 0; s < 3; s++) begin
                drive(1'b1, tbl[k], 2'd0);
                ncommit += int'(commit);
                checks++;
                if (commit !== (s == 2)) begin
                    errors++;
                    $display("FAIL tbl_commit d=%0d s=%0d got %b exp %b",
                             k, s, commit, s == 2);
                end
                if (s == 2) begin
                    checks++;
                    if (hex_out[3:0] !== k[3:0] || digit_valid[0] !== 1'b1) begin
                        errors++;
                        $display("FAIL tbl_hex got %h v=%b exp %h v=1",
                                 hex_out[3:0], digit_valid[0], k[3:0]);
                    end
                end
            end
        end
        checks++;
        if (ncommit != 16) begin
            errors++;
            $display("FAIL tbl_count got %0d exp 16", ncommit);
        end
    endtask

    task automatic test_glitch();
        logic [6:0] seq [6] = '{7'h40, 7'h40, 7'h79, 7'h40, 7'h40, 7'h40};
        for (int s = 0; s < 6; s++) begin
            drive(1'b1, seq[s], 2'd1);
            checks++;
            if (commit !== (s == 5)) begin
                errors++;
                $display("FAIL glitch_commit s=%0d got %b exp %b",
                         s, commit, s == 5);
            end
        end
        checks++;
        if (hex_out[7:4] !== 4'h0 || commit_idx !== 2'd1) begin
            errors++;
            $display("FAIL glitch_hex got %h idx %0d exp 0 idx 1",
                     hex_out[7:4], commit_idx);
        end
    endtask

    task automatic test_invalid();
        int nerr = 0;
        do_reset();
        for (int s = 0; s < 3; s++) drive(1'b1, 7'h40, 2'd2);
        for (int s = 0; s < 5; s++) begin
            drive(1'b1, 7'h7E, 2'd2);
            nerr += int'(err);
            checks++;
            if (commit !== 1'b0) begin
                errors++;
                $display("FAIL inv_commit got %b exp 0", commit);
            end
        end
        checks++;
        if (nerr != 1 || err_cnt !== 8'd1 || digit_valid[2] !== 1'b0) begin
            errors++;
            $display("FAIL inv_one got errs=%0d cnt=%0d v=%b exp 1 1 0",
                     nerr, err_cnt, digit_valid[2]);
        end
        for (int r = 0; r < 256; r++) begin
            for (int s = 0; s < 3; s++) begin
                drive(1'b1, (r % 2 == 0) ? 7'h7D : 7'h7E, 2'd2);
            end
        end
        checks++;
        if (err_cnt !== 8'd255) begin
            errors++;
            $display("FAIL inv_sat got %0d exp 255", err_cnt);
        end
    endtask

    task automatic test_frame();
        do_reset();
        for (int d = 0; d < 4; d++) begin
            for (int s = 0; s < 3; s++) begin
                drive(1'b1, tbl[d+1], IDX_W'(d));
                checks++;
                if (frame_done !== (d == 3 && s == 2)) begin
                    errors++;
                    $display("FAIL frame_pulse d=%0d s=%0d got %b",
                             d, s, frame_done);
                end
            end
        end
        checks++;
        if (commit_idx !== 2'd3 || hex_out !== 16'h4321 ||
            digit_valid !== 4'hF) begin
            errors++;
            $display("FAIL frame_state got idx=%0d hex=%h v=%h exp 3 4321 F",
                     commit_idx, hex_out, digit_valid);
        end
    endtask

    task automatic test_reset_abort();
        drive(1'b1, 7'h12, 2'd0);
        drive(1'b1, 7'h12, 2'd0);
        do_reset();
        checks++;
        if (hex_out !== '0 || digit_valid !== '0 || err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL abort_rst got hex=%h v=%b cnt=%0d exp 0",
                     hex_out, digit_valid, err_cnt);
        end
        drive(1'b1, 7'h12, 2'd0);
        checks++;
        if (commit !== 1'b0) begin
            errors++;
            $display("FAIL abort_commit got %b exp 0", commit);
        end
    endtask

    task automatic test_hold();
        do_reset();
        drive(1'b1, 7'h24, 2'd3);
        drive(1'b1, 7'h24, 2'd3);
        for (int s = 0; s < 4; s++) begin
            drive(1'b0, 7'h79, 2'd1);
            checks++;
            if (commit !== 1'b0 || err !== 1'b0) begin
                errors++;
                $display("FAIL hold_pulse got c=%b e=%b exp 0", commit, err);
            end
        end
        drive(1'b1, 7'h24, 2'd3);
        checks++;
        if (commit !== 1'b1 || hex_out[15:12] !== 4'h2) begin
            errors++;
            $display("FAIL hold_commit got c=%b hex=%h exp 1 2",
                     commit, hex_out[15:12]);
        end
        drive(1'b1, 7'h24, 2'd3);
        checks++;
        if (commit !== 1'b0) begin
            errors++;
            $display("FAIL hold_repeat got %b exp 0", commit);
        end
    endtask

    task automatic test_blank();
        logic [7:0] cnt0;
        do_reset();
        for (int s = 0; s < 3; s++) drive(1'b1, 7'h79, 2'd0);
        cnt0 = err_cnt;
        for (int s = 0; s < 3; s++) drive(1'b1, 7'h7F, 2'd0);
        checks++;
        if (digit_valid[0] !== 1'b0 || commit !== 1'b0) begin
            errors++;
            $display("FAIL blank_valid got v=%b c=%b exp 0 0",
                     digit_valid[0], commit);
        end
`ifdef SEG7_BLANK_DETECT_EN
        checks++;
        if (err !== 1'b0 || err_cnt !== cnt0) begin
            errors++;
            $display("FAIL blank_err got e=%b cnt=%0d exp 0 %0d",
                     err, err_cnt, cnt0);
        end
`else
        checks++;
        if (err !== 1'b1 || err_cnt !== cnt0 + 8'd1) begin
            errors++;
            $display("FAIL blank_err got e=%b cnt=%0d exp 1 %0d",
                     err, err_cnt, cnt0 + 8'd1);
        end
`endif
    endtask

    task automatic test_random();
        logic [6:0]       seg;
        logic [IDX_W-1:0] idx;
        int               sel;
        int               hold;
        do_reset();
        for (int r = 0; r < 120; r++) begin
            sel  = $urandom_range(0, 19);
            seg  = (sel < 16) ? tbl[sel] :
                   (sel == 18) ? 7'h7F :
                   (sel == 19) ? 7'h7E : 7'($urandom);
            idx  = IDX_W'($urandom_range(0, DIGITS-1));
            hold = $urandom_range(1, 5);
            for (int s = 0; s < hold; s++) begin
                drive($urandom_range(0, 3) != 0, seg, idx);
                checks++;
                if (commit !== e_commit || err !== e_err ||
                    frame_done !== e_frame) begin
                    errors++;
                    $display("FAIL rnd_pulse got c%b e%b f%b exp c%b e%b f%b",
                             commit, err, frame_done,
                             e_commit, e_err, e_frame);
                end
                checks++;
                if (e_commit && commit_idx !== e_idx) begin
                    errors++;
                    $display("FAIL rnd_idx got %0d exp %0d",
                             commit_idx, e_idx);
                end
                checks++;
                if (hex_out !== m_hex_vec() || digit_valid !== m_valid ||
                    err_cnt !== 8'(m_err_cnt)) begin
                    errors++;
                    $display("FAIL rnd_state got %h %b %0d exp %h %b %0d",
                             hex_out, digit_valid, err_cnt,
                             m_hex_vec(), m_valid, m_err_cnt);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_table();
        test_glitch();
        test_invalid();
        test_frame();
        test_reset_abort();
        test_hold();
        test_blank();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
